// File: rtl/gray_step_checker_if.sv
// Bus between the ripple counter stage and the Gray step checker:
// the sampled binary count in, registered Gray code and status flags out.
interface gray_step_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     bin_in;
  logic                 in_valid;
  logic [WIDTH-1:0]     gray_out;
  logic                 gray_valid;
  logic                 step_err;
  logic                 wrap_pulse;
  logic                 dir_up;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output bin_in, in_valid,
    input  gray_out, gray_valid, step_err, wrap_pulse, dir_up, locked, err_count
  );

  modport slave (
    input  bin_in, in_valid,
    output gray_out, gray_valid, step_err, wrap_pulse, dir_up, locked, err_count
  );
endinterface

// File: rtl/gray_step_checker.sv
// Registers sampled count values, converts them to Gray code and checks that
// consecutive samples move by 0 or +/-1 in a consistent, learned direction.
module gray_step_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input logic                 clk,
  input logic                 set,
  gray_step_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     s1_q, s1_d;
  logic                 s1_v_q, s1_v_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     gray_q, gray_d;
  logic                 gray_valid_q, gray_valid_d;
  logic                 step_err_q, step_err_d;
  logic                 wrap_q, wrap_d;
  logic                 dir_up_q, dir_up_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] delta;
  logic             step_zero, step_up, step_dn;

  // Modulo-2**WIDTH difference falls out of the natural WIDTH-bit wrap.
  assign delta     = s1_q - prev_q;
  assign step_zero = (delta == '0);
  assign step_up   = (delta == WIDTH'(1));
  assign step_dn   = (delta == ONES);

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    s1_d         = s1_q;
    s1_v_d       = bus.in_valid;
    prev_d       = prev_q;
    gray_d       = gray_q;
    gray_valid_d = 1'b0;
    step_err_d   = 1'b0;
    wrap_d       = 1'b0;
    dir_up_d     = dir_up_q;
    err_count_d  = err_count_q;

    if (bus.in_valid) begin
      s1_d = bus.bin_in;
    end

    if (s1_v_q) begin
      gray_d       = s1_q ^ (s1_q >> 1);
      gray_valid_d = 1'b1;
      prev_d       = s1_q;

      unique case (state_q)
        IDLE: begin
          state_d  = ACQUIRE;
          dir_up_d = 1'b0;
        end
        ACQUIRE: begin
          if (step_up) begin
            dir_up_d = 1'b1;
            state_d  = TRACK;
          end else if (step_dn) begin
            dir_up_d = 1'b0;
            state_d  = TRACK;
          end else if (!step_zero) begin
            step_err_d = 1'b1;
          end
        end
        TRACK: begin
          if (!step_zero && !((step_up && dir_up_q) || (step_dn && !dir_up_q))) begin
            step_err_d = 1'b1;
            state_d    = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Only a legal, nonzero step across the all-ones/zero boundary is a wrap.
      wrap_d = !step_err_d && !step_zero && (state_q != IDLE) &&
               (((prev_q == ONES) && (s1_q == '0)) ||
                ((prev_q == '0) && (s1_q == ONES)));

      if (step_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (set) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s1_v_q       <= 1'b0;
      prev_q       <= '0;
      gray_q       <= '0;
      gray_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
      wrap_q       <= 1'b0;
      dir_up_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s1_v_q       <= s1_v_d;
      prev_q       <= prev_d;
      gray_q       <= gray_d;
      gray_valid_q <= gray_valid_d;
      step_err_q   <= step_err_d;
      wrap_q       <= wrap_d;
      dir_up_q     <= dir_up_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.gray_out   = gray_q;
  assign bus.gray_valid = gray_valid_q;
  assign bus.step_err   = step_err_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.locked     = (state_q == TRACK);
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_gray_step_checker.sv
// Bench for gray_step_checker: directed scenarios plus a random walk, all
// compared every cycle against a transaction-level model of the step rules.
module tb_gray_step_checker;

  localparam int W    = 4;
  localparam int EW   = 8;
  localparam int MODV = 1 << W;
  localparam int MAXV = MODV - 1;

  logic clk = 1'b0;
  logic set = 1'b1;
  always #5 clk = ~clk;

  gray_step_checker_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

  gray_step_checker #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk (clk),
    .set (set),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: phase 0 = nothing seen yet, 1 = searching for a direction,
  // 2 = direction known. pend holds the sample that will be judged next edge.
  typedef struct packed {
    logic [1:0]    phase;
    logic          dir;
    logic [W-1:0]  prev;
    logic [EW-1:0] errs;
    logic [W-1:0]  gray;
    logic          gv;
    logic          se;
    logic          wr;
    logic          pend_v;
    logic [W-1:0]  pend;
    logic          rst;
  } model_t;

  function automatic model_t next_model(model_t m, logic rst, logic v, logic [W-1:0] b);
    model_t n;
    int     d;
    bit     bad;
    n     = m;
    n.gv  = 1'b0;
    n.se  = 1'b0;
    n.wr  = 1'b0;
    n.rst = rst;
    if (rst) begin
      n     = '0;
      n.rst = 1'b1;
      return n;
    end
    if (m.pend_v) begin
      d    = (int'(m.pend) - int'(m.prev) + MODV) % MODV;
      bad  = 1'b0;
      n.gv = 1'b1;
      n.gray = m.pend ^ W'(int'(m.pend) / 2);
      if (m.phase == 2'd0) begin
        n.phase = 2'd1;
        n.dir   = 1'b0;
      end else if (d != 0) begin
        if (m.phase == 2'd1 && (d == 1 || d == MAXV)) begin
          n.phase = 2'd2;
          n.dir   = (d == 1);
        end else if (m.phase == 2'd2 && ((d == 1 && m.dir) || (d == MAXV && !m.dir))) begin
          n.phase = 2'd2;
        end else begin
          bad     = 1'b1;
          n.phase = 2'd1;
        end
        n.wr = !bad && ((int'(m.prev) == MAXV && m.pend == '0) ||
                        (m.prev == '0 && int'(m.pend) == MAXV));
      end
      n.se = bad;
      if (bad && m.errs != '1) n.errs = m.errs + EW'(1);
      n.prev = m.pend;
    end
    n.pend_v = v;
    n.pend   = b;
    return n;
  endfunction

  model_t mdl = '0;
  always @(posedge clk) mdl <= next_model(mdl, set, bus.in_valid, bus.bin_in);

  typedef struct {
    logic [W-1:0] gray;
    logic         se;
    logic         wr;
    logic         lk;
    logic         dir;
  } res_t;

  res_t         res_q[$];
  bit           cmp_en = 1'b0;
  bit           last_ok = 1'b0;
  logic [W-1:0] last_gray = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gray_out",   32'(bus.gray_out),   32'(mdl.gray));
      check("gray_valid", 32'(bus.gray_valid), 32'(mdl.gv));
      check("step_err",   32'(bus.step_err),   32'(mdl.se));
      check("wrap_pulse", 32'(bus.wrap_pulse), 32'(mdl.wr));
      check("dir_up",     32'(bus.dir_up),     32'(mdl.dir));
      check("locked",     32'(bus.locked),     32'(mdl.phase == 2'd2));
      check("err_count",  32'(bus.err_count),  32'(mdl.errs));
      if (mdl.rst) last_ok = 1'b0;
      if (bus.gray_valid === 1'b1) begin
        if (last_ok && bus.step_err === 1'b0 && bus.gray_out !== last_gray)
          check("gray_one_bit", 32'($countones(bus.gray_out ^ last_gray)), 32'd1);
        last_gray = bus.gray_out;
        last_ok   = 1'b1;
        res_q.push_back('{bus.gray_out, bus.step_err, bus.wrap_pulse, bus.locked, bus.dir_up});
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.bin_in   = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    set = 1'b0;
    res_q.delete();
  endtask

  task automatic flush();
    repeat (3) drive(1'b0, '0);
  endtask

  logic [W-1:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  initial begin
    logic [W-1:0] cur;
    bit           wdir;
    int           p;

    // Reset held two edges while a sample is offered.
    bus.in_valid = 1'b1;
    bus.bin_in   = 4'd5;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_gray",   32'(bus.gray_out),   32'd0);
    check("rst_locked", 32'(bus.locked),     32'd0);
    check("rst_errcnt", 32'(bus.err_count),  32'd0);
    flush();
    check("rst_no_pulse", 32'(res_q.size()), 32'd0);

    // Up count with wrap.
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, W'(i % 16));
    flush();
    check("up_count", 32'(res_q.size()), 32'd18);
    for (int i = 0; i < res_q.size(); i++) begin
      check("up_gray", 32'(res_q[i].gray), 32'(gray_tbl[i[3:0]]));
      check("up_wrap", 32'(res_q[i].wr),   32'(i == 16));
      check("up_err",  32'(res_q[i].se),   32'd0);
      if (i >= 1) check("up_locked", 32'(res_q[i].lk & res_q[i].dir), 32'd1);
    end

    // Down count with wrap.
    do_reset();
    for (int i = 15; i >= 0; i--) drive(1'b1, W'(i));
    drive(1'b1, 4'd15);
    flush();
    check("dn_count", 32'(res_q.size()), 32'd17);
    for (int i = 0; i < res_q.size(); i++) begin
      check("dn_wrap", 32'(res_q[i].wr), 32'(i == 16));
      if (i >= 1) check("dn_locked", 32'({res_q[i].lk, res_q[i].dir}), 32'b10);
    end
    check("dn_errcnt", 32'(bus.err_count), 32'd0);

    // Direction reversal, then a jump.
    do_reset();
    drive(1'b1, 4'd3); drive(1'b1, 4'd4); drive(1'b1, 4'd5);
    drive(1'b1, 4'd4); drive(1'b1, 4'd9);
    flush();
    check("viol_count", 32'(res_q.size()), 32'd5);
    if (res_q.size() == 5) begin
      check("viol_err3",  32'(res_q[3].se), 32'd1);
      check("viol_lock3", 32'(res_q[3].lk), 32'd0);
      check("viol_err4",  32'(res_q[4].se), 32'd1);
      check("viol_err2",  32'(res_q[2].se), 32'd0);
    end
    check("viol_errcnt", 32'(bus.err_count), 32'd2);

    // Repeats and gaps.
    do_reset();
    drive(1'b1, 4'd7); drive(1'b1, 4'd7);
    repeat (3) drive(1'b0, 4'd3);
    drive(1'b1, 4'd8); drive(1'b1, 4'd8); drive(1'b1, 4'd9);
    flush();
    check("gap_count", 32'(res_q.size()), 32'd5);
    if (res_q.size() == 5) begin
      check("gap_lock1", 32'(res_q[1].lk), 32'd0);
      check("gap_lock2", 32'(res_q[2].lk), 32'd1);
      check("gap_gray4", 32'(res_q[4].gray), 32'd13);
    end
    check("gap_errcnt", 32'(bus.err_count), 32'd0);

    // Saturation, then reset with a sample in flight.
    do_reset();
    drive(1'b1, 4'd0);
    for (int i = 0; i < 301; i++) drive(1'b1, (i % 2 == 0) ? 4'd8 : 4'd0);
    flush();
    check("sat_errcnt", 32'(bus.err_count), 32'd255);
    res_q.delete();
    drive(1'b1, 4'd3);
    @(negedge clk);
    set          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    set = 1'b0;
    flush();
    check("abort_no_pulse", 32'(res_q.size()), 32'd0);
    check("abort_errcnt",   32'(bus.err_count), 32'd0);

    // Random walk with occasional reversals, jumps, gaps and resets.
    do_reset();
    cur  = 4'($urandom);
    wdir = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      set          = ($urandom_range(0, 99) < 2);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      p = int'($urandom_range(0, 99));
      if (p < 55)      cur = wdir ? cur + 4'd1 : cur - 4'd1;
      else if (p < 70) cur = cur;
      else if (p < 78) cur = wdir ? cur - 4'd1 : cur + 4'd1;
      else if (p < 90) wdir = !wdir;
      else             cur = 4'($urandom);
      bus.bin_in = cur;
    end
    @(negedge clk);
    set = 1'b0;
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
